idma_obi_job_launcher: RTL
==========================

IDMA_OBI_JOB_LAUNCHER -- requirements
Module: idma_obi_job_launcher

Interface
REQ-001 Parameters SHALL be (name, default, meaning): obi_req_t, magia_tile_pkg::core_obi_data_req_t, OBI request type; obi_rsp_t, magia_tile_pkg::core_obi_data_rsp_t, OBI response type; IDMA_BASE_ADDR, magia_tile_pkg::IDMA_CTRL_ADDR_START, iDMA control base; POLL_GAP, 4, idle cycles between DONE_ID polls (1..255).
REQ-002 clk_i  in  1  sole clock; all state on its rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 job_valid_i  in  1  job descriptor valid.
REQ-005 job_ready_o  out  1  launcher accepts a job; high only in IDLE.
REQ-006 job_dir_i  in  1  0 = AXI2OBI (L2->L1), 1 = OBI2AXI (L1->L2).
REQ-007 job_src_i / job_dst_i / job_len_i  in  32 each  source address, destination address, byte length.
REQ-008 obi_req_o  out  obi_req_t  OBI initiator request toward the iDMA control decoder.
REQ-009 obi_rsp_i  in  obi_rsp_t  OBI response (gnt, rvalid, r.rdata, r.err).
REQ-010 done_valid_o  out  1  one-cycle pulse on job completion or abort.
REQ-011 done_id_o  out  32  transfer ID of completed job, valid with done_valid_o.
REQ-012 error_o  out  1  qualifies done_valid_o; 1 = job aborted.
REQ-013 busy_o  out  1  high in every state except IDLE.

Function
REQ-014 Job is captured when job_valid_i && job_ready_o; descriptor and direction are registered, and inputs are ignored until return to IDLE.
REQ-015 Target address SHALL be IDMA_BASE_ADDR + (dir ? 0x200 : 0x0) + register offset; offsets are DST 0xd0, SRC 0xd8, LENGTH 0xe0, NEXT_ID_0 0x44, DONE_ID_0 0x84.
REQ-016 States: IDLE, WR_DST, WR_SRC, WR_LEN, RD_NEXT, POLL_WAIT, RD_DONE, FINISH; each access state has a request phase and a response phase.
REQ-017 Request phase: req=1 with stable addr/we/wdata/be=4'hF until the cycle gnt=1; request is first driven the cycle after state entry.
REQ-018 Response phase: req=0; wait for rvalid; at most one outstanding transaction.
REQ-019 Sequence: WR_DST(wdata=dst) -> WR_SRC(wdata=src) -> WR_LEN(wdata=len) -> RD_NEXT (read; rdata latched as launch_id) -> POLL_WAIT.
REQ-020 POLL_WAIT counts POLL_GAP cycles, then moves to RD_DONE; RD_DONE reads DONE_ID_0.
REQ-021 If RD_DONE rdata == launch_id, go to FINISH; otherwise return to POLL_WAIT with the counter reloaded.
REQ-022 FINISH asserts done_valid_o=1, done_id_o=launch_id, and error_o=0 for exactly one cycle, then goes to IDLE.
REQ-023 rvalid with r.err=1 in any access state aborts: next cycle goes to FINISH with error_o=1, done_id_o=0, and no further OBI requests.
REQ-024 job_len_i==0 issues no OBI traffic; FINISH follows the capture cycle with error_o=0 and done_id_o=0.
REQ-025 RD_NEXT returning 0 (iDMA rejected the job) SHALL be treated as an abort (error_o=1).
REQ-026 gnt and rvalid in the same cycle SHALL complete the access in that cycle and advance state.
REQ-027 rvalid without an outstanding request SHALL be ignored.
REQ-028 Poll ID compare is full 32-bit equality; there is no timeout.
REQ-029 In IDLE, obi_req_o SHALL be all-zero.
REQ-030 The OBI fields a.aid and a.a_optional SHALL be 0.

Reset
REQ-031 When rst_ni=0, asynchronously: state=IDLE, obi_req_o='0, job_ready_o=1, busy_o=0, done_valid_o=0, error_o=0, done_id_o=0, descriptor/launch_id/poll counter=0.
REQ-032 Reset mid-transaction drops any pending request without a completion pulse; the first post-reset cycle SHALL be IDLE.

Verification
REQ-033 dir=0, src=0x1000_0000, dst=BASE_L1+0x100, len=0x40, gnt immediate, NEXT_ID=5, DONE_ID=5 on first poll -> writes at BASE+0xd0/0xd8/0xe0, read at BASE+0x44, read at BASE+0x84, then done_valid_o with done_id_o=5 and error_o=0.
REQ-034 dir=1, same job, gnt delayed 3 cycles per access -> addresses BASE+0x2d0/0x2d8/0x2e0/0x244/0x284; req and payload held stable while gnt=0.
REQ-035 NEXT_ID=7; DONE_ID returns 6, 6, 7 -> three polls spaced ≥POLL_GAP idle cycles apart, then done_id_o=7.
REQ-036 r.err=1 on WR_SRC response -> no LENGTH write; one-cycle done_valid_o with error_o=1; then job_ready_o=1.
REQ-037 len=0 -> zero OBI requests; done_valid_o with error_o=0 two cycles after job handshake.
REQ-038 rst_ni pulsed low during POLL_WAIT -> all outputs at reset values immediately; new job accepted afterward and completes normally.

Source files
------------

// File: rtl/idma_obi_job_launcher.sv
`default_nettype none
// ============================================================================
//  Module   : idma_obi_job_launcher
//  Purpose  : Programs one iDMA transfer through its OBI control port
//             (DST, SRC, LENGTH writes), launches it by reading NEXT_ID,
//             then polls DONE_ID every POLL_GAP cycles until the launched
//             ID is reported done. Signals completion or abort with a
//             one-cycle done pulse.
//  Ports    : clk_i, rst_ni            clock, async active-low reset
//             job_valid_i/job_ready_o  job descriptor handshake
//             job_dir_i, job_src_i, job_dst_i, job_len_i  descriptor
//             obi_req_o/obi_rsp_i      OBI initiator toward iDMA decoder
//             done_valid_o, done_id_o, error_o  completion report
//             busy_o                   high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================

// Tile-level OBI data types and address map used as parameter defaults.
package magia_tile_pkg;
    localparam logic [31:0] IDMA_CTRL_ADDR_START = 32'h0002_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [0:0]  a_optional;
    } core_obi_data_a_chan_t;

    typedef struct packed {
        core_obi_data_a_chan_t a;
        logic                  req;
    } core_obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic [0:0]  r_optional;
    } core_obi_data_r_chan_t;

    typedef struct packed {
        core_obi_data_r_chan_t r;
        logic                  gnt;
        logic                  rvalid;
    } core_obi_data_rsp_t;
endpackage

module idma_obi_job_launcher #(
    parameter type         obi_req_t      = magia_tile_pkg::core_obi_data_req_t,
    parameter type         obi_rsp_t      = magia_tile_pkg::core_obi_data_rsp_t,
    parameter logic [31:0] IDMA_BASE_ADDR = magia_tile_pkg::IDMA_CTRL_ADDR_START,
    parameter int unsigned POLL_GAP       = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        job_valid_i,
    output logic        job_ready_o,
    input  logic        job_dir_i,
    input  logic [31:0] job_src_i,
    input  logic [31:0] job_dst_i,
    input  logic [31:0] job_len_i,
    output obi_req_t    obi_req_o,
    input  obi_rsp_t    obi_rsp_i,
    output logic        done_valid_o,
    output logic [31:0] done_id_o,
    output logic        error_o,
    output logic        busy_o
);

    localparam logic [31:0] c_dir_stride  = 32'h0000_0200;
    localparam logic [31:0] c_off_dst     = 32'h0000_00d0;
    localparam logic [31:0] c_off_src     = 32'h0000_00d8;
    localparam logic [31:0] c_off_len     = 32'h0000_00e0;
    localparam logic [31:0] c_off_next_id = 32'h0000_0044;
    localparam logic [31:0] c_off_done_id = 32'h0000_0084;
    localparam logic [7:0]  c_poll_gap    = 8'(POLL_GAP);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_DST    = 4'd1,
        S_WR_SRC    = 4'd2,
        S_WR_LEN    = 4'd3,
        S_RD_NEXT   = 4'd4,
        S_POLL_WAIT = 4'd5,
        S_RD_DONE   = 4'd6,
        S_FINISH    = 4'd7
    } state_t;

    state_t      r_state;
    logic        r_dir;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_len;
    logic [31:0] r_launch_id;
    logic [7:0]  r_poll_cnt;
    logic        r_first;     // first cycle of a state: load request / pulse
    logic        r_pend;      // granted, waiting for rvalid
    logic        r_abort;
    obi_req_t    r_obi_req;
    logic        r_done_valid;
    logic [31:0] r_done_id;
    logic        r_error;

    // Register select and write payload for the current access state.
    logic [31:0] w_offset;
    logic [31:0] w_wdata;
    logic        w_we;
    logic [31:0] w_addr;

    always_comb begin
        w_offset = c_off_dst;
        w_wdata  = '0;
        w_we     = 1'b0;
        case (r_state)
            S_WR_DST:  begin w_offset = c_off_dst; w_wdata = r_dst; w_we = 1'b1; end
            S_WR_SRC:  begin w_offset = c_off_src; w_wdata = r_src; w_we = 1'b1; end
            S_WR_LEN:  begin w_offset = c_off_len; w_wdata = r_len; w_we = 1'b1; end
            S_RD_NEXT: w_offset = c_off_next_id;
            S_RD_DONE: w_offset = c_off_done_id;
            default:   ;
        endcase
    end

    assign w_addr = IDMA_BASE_ADDR + (r_dir ? c_dir_stride : 32'h0) + w_offset;

    // An access completes on rvalid either together with its grant or later
    // while pending; rvalid at any other time belongs to nobody.
    logic w_rsp;
    assign w_rsp = (r_obi_req.req && obi_rsp_i.gnt && obi_rsp_i.rvalid) ||
                   (r_pend && obi_rsp_i.rvalid);

    // Successor of an access state once its response arrives.
    state_t w_after;
    logic   w_fail;

    always_comb begin
        w_after = S_FINISH;
        w_fail  = 1'b1;
        if (!obi_rsp_i.r.err) begin
            case (r_state)
                S_WR_DST: begin w_after = S_WR_SRC; w_fail = 1'b0; end
                S_WR_SRC: begin w_after = S_WR_LEN; w_fail = 1'b0; end
                S_WR_LEN: begin w_after = S_RD_NEXT; w_fail = 1'b0; end
                S_RD_NEXT: begin
                    // NEXT_ID of zero means the iDMA refused the job.
                    if (obi_rsp_i.r.rdata != 32'h0) begin
                        w_after = S_POLL_WAIT;
                        w_fail  = 1'b0;
                    end
                end
                S_RD_DONE: begin
                    w_fail  = 1'b0;
                    w_after = (obi_rsp_i.r.rdata == r_launch_id) ? S_FINISH : S_POLL_WAIT;
                end
                default: ;
            endcase
        end
    end

    logic w_unused_rsp;
    assign w_unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_dir        <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_launch_id  <= '0;
            r_poll_cnt   <= '0;
            r_first      <= 1'b0;
            r_pend       <= 1'b0;
            r_abort      <= 1'b0;
            r_obi_req    <= '0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_obi_req <= '0;
                    r_pend    <= 1'b0;
                    if (job_valid_i) begin
                        r_dir       <= job_dir_i;
                        r_src       <= job_src_i;
                        r_dst       <= job_dst_i;
                        r_len       <= job_len_i;
                        r_launch_id <= '0;
                        r_abort     <= 1'b0;
                        r_first     <= 1'b1;
                        r_state     <= (job_len_i == 32'h0) ? S_FINISH : S_WR_DST;
                    end
                end

                S_WR_DST, S_WR_SRC, S_WR_LEN, S_RD_NEXT, S_RD_DONE: begin
                    if (r_first) begin
                        r_first              <= 1'b0;
                        r_obi_req            <= '0;
                        r_obi_req.req        <= 1'b1;
                        r_obi_req.a.addr     <= w_addr;
                        r_obi_req.a.we       <= w_we;
                        r_obi_req.a.be       <= 4'hF;
                        r_obi_req.a.wdata    <= w_wdata;
                    end else begin
                        if (r_obi_req.req && obi_rsp_i.gnt) begin
                            r_obi_req <= '0;
                            r_pend    <= !obi_rsp_i.rvalid;
                        end
                        if (w_rsp) begin
                            r_pend     <= 1'b0;
                            r_state    <= w_after;
                            r_abort    <= w_fail;
                            r_first    <= 1'b1;
                            r_poll_cnt <= c_poll_gap;
                            if (r_state == S_RD_NEXT) begin
                                r_launch_id <= obi_rsp_i.r.rdata;
                            end
                        end
                    end
                end

                S_POLL_WAIT: begin
                    if (r_poll_cnt <= 8'd1) begin
                        r_state <= S_RD_DONE;
                        r_first <= 1'b1;
                    end else begin
                        r_poll_cnt <= r_poll_cnt - 8'd1;
                    end
                end

                S_FINISH: begin
                    if (r_first) begin
                        r_first      <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_error      <= r_abort;
                        r_done_id    <= r_abort ? 32'h0 : r_launch_id;
                    end else begin
                        r_done_valid <= 1'b0;
                        r_error      <= 1'b0;
                        r_done_id    <= '0;
                        r_state      <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign obi_req_o    = r_obi_req;
    assign job_ready_o  = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign done_valid_o = r_done_valid;
    assign done_id_o    = r_done_id;
    assign error_o      = r_error;

endmodule
`default_nettype wire
